// File: rtl/bcu_pkg.sv
// Shared constants and FSM state type for the branch-condition unit.
package bcu_pkg;

    localparam int COND_NEVER     = 0;
    localparam int COND_ALWAYS    = 1;
    localparam int COND_FLAG_BASE = 2;

    typedef enum logic {
        BCU_EMPTY = 1'b0,
        BCU_FULL  = 1'b1
    } bcu_state_e;

endpackage

// File: rtl/bcu_cond_sel.sv
// Combinational condition decode: never / always / effective-flag lookup.
// Codes at or above NUM_COND are illegal and always produce a not-taken result.
module bcu_cond_sel
    import bcu_pkg::*;
#(
    parameter int NUM_COND = 8,
    parameter int SEL_W    = 8,
    localparam int NUM_FLAGS = NUM_COND - COND_FLAG_BASE
) (
    input  logic [NUM_FLAGS-1:0] eff_flags,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 inv,
    output logic                 result,
    output logic                 illegal
);

    // Widen sel so the range check never truncates either operand.
    localparam int CMP_W = (SEL_W > 32) ? SEL_W : 32;

    logic [CMP_W-1:0] sel_ext;
    logic             cond;

    assign sel_ext = CMP_W'(sel);

    always_comb begin
        cond    = 1'b0;
        illegal = 1'b0;
        if (sel_ext >= CMP_W'(NUM_COND)) begin
            illegal = 1'b1;
        end else if (sel_ext == CMP_W'(COND_NEVER)) begin
            cond = 1'b0;
        end else if (sel_ext == CMP_W'(COND_ALWAYS)) begin
            cond = 1'b1;
        end else begin
            for (int i = 0; i < NUM_FLAGS; i++) begin
                if (sel_ext == CMP_W'(i + COND_FLAG_BASE)) begin
                    cond = eff_flags[i];
                end
            end
        end
        result = illegal ? 1'b0 : (cond ^ inv);
    end

endmodule

// File: rtl/branch_cond_unit.sv
// Branch-condition unit: ALU flag register, condition decode and a one-entry response stage.
// Optional consumed-response statistics counters are enabled with `define BCU_STATS_EN.
module branch_cond_unit
    import bcu_pkg::*;
#(
    parameter int NUM_COND = 8,
    parameter int SEL_W    = 8,
    parameter int CNT_W    = 16,
    localparam int NUM_FLAGS = NUM_COND - 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_FLAGS-1:0] flag_in,
    input  logic [NUM_FLAGS-1:0] flag_we,
    input  logic                 flush,
    input  logic                 req_valid,
    input  logic [SEL_W-1:0]     req_sel,
    input  logic                 req_inv,
    output logic                 req_ready,
    output logic                 rsp_valid,
    output logic                 rsp_taken,
    output logic                 rsp_illegal,
    input  logic                 rsp_ready,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     cnt_total,
    output logic [CNT_W-1:0]     cnt_taken
);

    logic [NUM_FLAGS-1:0] flag_q, flag_d;
    bcu_state_e           state_q, state_d;
    logic                 taken_q, taken_d;
    logic                 illegal_q, illegal_d;
    logic                 accept;
    logic                 consume;
    logic                 cond_result;
    logic                 cond_illegal;

    assign rsp_valid   = (state_q == BCU_FULL);
    assign rsp_taken   = taken_q;
    assign rsp_illegal = illegal_q;
    assign req_ready   = !flush && (!rsp_valid || rsp_ready);
    assign accept      = req_valid && req_ready;
    assign consume     = rsp_valid && rsp_ready;

    // The next flag value doubles as the bypassed view used by a same-cycle request.
    always_comb begin
        flag_d = (flag_we & flag_in) | (~flag_we & flag_q);
    end

    bcu_cond_sel #(
        .NUM_COND (NUM_COND),
        .SEL_W    (SEL_W)
    ) u_cond_sel (
        .eff_flags (flag_d),
        .sel       (req_sel),
        .inv       (req_inv),
        .result    (cond_result),
        .illegal   (cond_illegal)
    );

    always_comb begin
        state_d   = state_q;
        taken_d   = taken_q;
        illegal_d = illegal_q;
        case (state_q)
            BCU_EMPTY: if (accept) state_d = BCU_FULL;
            BCU_FULL:  if (rsp_ready && !accept) state_d = BCU_EMPTY;
            default:   state_d = BCU_EMPTY;
        endcase
        if (accept) begin
            taken_d   = cond_result;
            illegal_d = cond_illegal;
        end
        if (flush) begin
            state_d = BCU_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q    <= '0;
            state_q   <= BCU_EMPTY;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            flag_q    <= flag_d;
            state_q   <= state_d;
            taken_q   <= taken_d;
            illegal_q <= illegal_d;
        end
    end

`ifdef BCU_STATS_EN
    logic [CNT_W-1:0] cnt_total_q, cnt_total_d;
    logic [CNT_W-1:0] cnt_taken_q, cnt_taken_d;

    // Illegal responses are consumed but never counted; both counters saturate.
    always_comb begin
        cnt_total_d = cnt_total_q;
        cnt_taken_d = cnt_taken_q;
        if (cnt_clr) begin
            cnt_total_d = '0;
            cnt_taken_d = '0;
        end else if (consume && !illegal_q) begin
            if (cnt_total_q != {CNT_W{1'b1}}) cnt_total_d = cnt_total_q + CNT_W'(1);
            if (taken_q && (cnt_taken_q != {CNT_W{1'b1}})) cnt_taken_d = cnt_taken_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_total_q <= '0;
            cnt_taken_q <= '0;
        end else begin
            cnt_total_q <= cnt_total_d;
            cnt_taken_q <= cnt_taken_d;
        end
    end

    assign cnt_total = cnt_total_q;
    assign cnt_taken = cnt_taken_q;
`else
    logic stats_unused;
    assign stats_unused = cnt_clr ^ consume;
    assign cnt_total    = '0;
    assign cnt_taken    = '0;
`endif

endmodule
